// File: rtl/lcd_num_arbiter.sv
// Two-requester arbiter for the LCD display digit. Accepted values are applied on the
// trailing edge of the field sync and then held for a minimum number of frames.
module lcd_num_arbiter #(
    parameter logic [3:0]  DEFAULT_NUM     = 4'd0,
    parameter int unsigned MIN_HOLD_FRAMES = 8,
    parameter logic        VS_POL          = 1'b0
) (
    input  logic       lcd_clk,
    input  logic       sys_rst_n,
    input  logic       lcd_vs,
    input  logic       req0,
    input  logic [3:0] num0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] num1,
    output logic       ack1,
    output logic       err,
    output logic [3:0] disp_num,
    output logic       owner,
    output logic       busy
);

    localparam int unsigned NUM_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [NUM_W-1:0] MAX_NUM   = NUM_W'(9);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             vs_q;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             err_q, err_d;
    logic [NUM_W-1:0] disp_q, disp_d;
    logic             owner_q, owner_d;
    logic [NUM_W-1:0] pend_num_q, pend_num_d;
    logic             pend_owner_q, pend_owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             busy_q;

    logic             tick;
    logic             win;
    logic             take;
    logic             take_ok;
    logic             load;
    logic [NUM_W-1:0] take_num;

    // Frame boundary is the trailing edge of the sync pulse.
    assign tick = (vs_q == VS_POL) && (lcd_vs != VS_POL);

    // A pending ack closes the window so a still-high req is not captured twice.
    assign win      = !ack0_q && !ack1_q &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && owner_q && req0));
    assign take     = win && (req0 || req1);
    assign take_num = req0 ? num0 : num1;
    assign take_ok  = (take_num <= MAX_NUM);
    assign load     = take && take_ok;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_PEND;
            ST_PEND: if (tick) state_d = ST_HOLD;
            ST_HOLD: begin
                if (load) begin
                    state_d = ST_PEND;
                end else if (tick && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        disp_d       = disp_q;
        owner_d      = owner_q;
        pend_num_d   = pend_num_q;
        pend_owner_d = pend_owner_q;
        hold_cnt_d   = hold_cnt_q;

        if (take) begin
            ack0_d = req0;
            ack1_d = !req0;
            err_d  = !take_ok;
        end
        if (load) begin
            pend_num_d   = take_num;
            pend_owner_d = !req0;
        end

        case (state_q)
            ST_PEND: begin
                if (tick) begin
                    disp_d     = pend_num_q;
                    owner_d    = pend_owner_q;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (tick && !load && (hold_cnt_q != '1)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q         <= ~VS_POL;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            disp_q       <= DEFAULT_NUM;
            owner_q      <= 1'b0;
            pend_num_q   <= '0;
            pend_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            vs_q         <= lcd_vs;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err_q        <= err_d;
            disp_q       <= disp_d;
            owner_q      <= owner_d;
            pend_num_q   <= pend_num_d;
            pend_owner_q <= pend_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err      = err_q;
    assign disp_num = disp_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule
